// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1+ datapath and controller: opcodes,
// control-strobe bit positions, bus source select and the flags payload.
package sap_pkg;

  localparam int unsigned SAP_DATA_WIDTH = 8;
  localparam int unsigned SAP_ADDR_WIDTH = 4;
  localparam int unsigned SAP_OP_WIDTH   = SAP_DATA_WIDTH - SAP_ADDR_WIDTH;
  localparam int unsigned SAP_CTL_WIDTH  = 16;

  localparam logic [SAP_OP_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [SAP_OP_WIDTH-1:0] OP_LDA = 4'h1;
  localparam logic [SAP_OP_WIDTH-1:0] OP_ADD = 4'h2;
  localparam logic [SAP_OP_WIDTH-1:0] OP_SUB = 4'h3;
  localparam logic [SAP_OP_WIDTH-1:0] OP_STA = 4'h4;
  localparam logic [SAP_OP_WIDTH-1:0] OP_LDI = 4'h5;
  localparam logic [SAP_OP_WIDTH-1:0] OP_JMP = 4'h6;
  localparam logic [SAP_OP_WIDTH-1:0] OP_JC  = 4'h7;
  localparam logic [SAP_OP_WIDTH-1:0] OP_JZ  = 4'h8;
  localparam logic [SAP_OP_WIDTH-1:0] OP_OUT = 4'he;
  localparam logic [SAP_OP_WIDTH-1:0] OP_HLT = 4'hf;

  // Bit positions of the controller's 16-bit control word
  localparam int unsigned CTL_HLT = 15;
  localparam int unsigned CTL_MI  = 14;
  localparam int unsigned CTL_RI  = 13;
  localparam int unsigned CTL_RO  = 12;
  localparam int unsigned CTL_IO  = 11;
  localparam int unsigned CTL_II  = 10;
  localparam int unsigned CTL_AI  = 9;
  localparam int unsigned CTL_AO  = 8;
  localparam int unsigned CTL_EO  = 7;
  localparam int unsigned CTL_SU  = 6;
  localparam int unsigned CTL_BI  = 5;
  localparam int unsigned CTL_OI  = 4;
  localparam int unsigned CTL_CE  = 3;
  localparam int unsigned CTL_CO  = 2;
  localparam int unsigned CTL_J   = 1;
  localparam int unsigned CTL_FI  = 0;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_IR   = 3'd1,
    BUS_RAM  = 3'd2,
    BUS_A    = 3'd3,
    BUS_ALU  = 3'd4,
    BUS_PC   = 3'd5
  } bus_src_e;

  typedef struct packed {
    logic carry;
    logic zero;
  } sap_flags_t;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit for the SAP-1+ datapath; subtract is A + ~B + 1.
module sap_alu
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAP_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  subtract,
  output logic [DATA_WIDTH-1:0] result_c,
  output logic                  carry_c,
  output logic                  zero_c
);

  logic [DATA_WIDTH-1:0] b_operand_c;
  logic [DATA_WIDTH:0]   sum_c;

  always_comb begin
    b_operand_c = subtract ? ~b : b;
    sum_c       = {1'b0, a} + {1'b0, b_operand_c} + (DATA_WIDTH+1)'(subtract);
    result_c    = sum_c[DATA_WIDTH-1:0];
    carry_c     = sum_c[DATA_WIDTH];
    zero_c      = (result_c == '0);
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1+ datapath: shared bus, A/B, ALU, flags, IR, PC, MAR, RAM and output register.
// Optional multi-driver bus check is enabled with the SAP_BUS_CHECK_EN macro.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAP_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SAP_ADDR_WIDTH
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_halt,
  input  logic                             i_memory_address_in,
  input  logic                             i_ram_in,
  input  logic                             i_ram_out,
  input  logic                             i_instruction_in,
  input  logic                             i_instruction_out,
  input  logic                             i_register_a_in,
  input  logic                             i_register_a_out,
  input  logic                             i_alu_out,
  input  logic                             i_alu_subtract,
  input  logic                             i_register_b_in,
  input  logic                             i_register_output_in,
  input  logic                             i_program_counter_increment,
  input  logic                             i_program_counter_out,
  input  logic                             i_program_counter_jump,
  input  logic                             i_register_flags_in,
  input  logic                             i_prog_we,
  input  logic [ADDR_WIDTH-1:0]            i_prog_addr,
  input  logic [DATA_WIDTH-1:0]            i_prog_data,
  output logic [DATA_WIDTH-ADDR_WIDTH-1:0] o_opcode,
  output logic                             o_flag_overflow,
  output logic                             o_flag_zero,
  output logic [DATA_WIDTH-1:0]            o_out,
  output logic [DATA_WIDTH-1:0]            o_bus,
  output logic [ADDR_WIDTH-1:0]            o_pc,
  output logic                             o_bus_conflict
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] reg_a;
  logic [DATA_WIDTH-1:0] reg_b;
  logic [DATA_WIDTH-1:0] reg_ir;
  logic [DATA_WIDTH-1:0] reg_out;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] mar;
  sap_flags_t            flags;
  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

  bus_src_e              bus_src_c;
  logic [DATA_WIDTH-1:0] bus_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;
  logic [DATA_WIDTH-1:0] alu_result_c;
  logic                  alu_carry_c;
  logic                  alu_zero_c;

  sap_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a        (reg_a),
    .b        (reg_b),
    .subtract (i_alu_subtract),
    .result_c (alu_result_c),
    .carry_c  (alu_carry_c),
    .zero_c   (alu_zero_c)
  );

  assign ram_rdata_c = ram[mar];

  // Fixed-priority bus driver select; lower-priority drivers are ignored
  always_comb begin
    bus_src_c = BUS_NONE;
    if (i_instruction_out) begin
      bus_src_c = BUS_IR;
    end else if (i_ram_out) begin
      bus_src_c = BUS_RAM;
    end else if (i_register_a_out) begin
      bus_src_c = BUS_A;
    end else if (i_alu_out) begin
      bus_src_c = BUS_ALU;
    end else if (i_program_counter_out) begin
      bus_src_c = BUS_PC;
    end
  end

  always_comb begin
    bus_c = '0;
    unique case (bus_src_c)
      BUS_IR:  bus_c = DATA_WIDTH'(reg_ir[ADDR_WIDTH-1:0]);
      BUS_RAM: bus_c = ram_rdata_c;
      BUS_A:   bus_c = reg_a;
      BUS_ALU: bus_c = alu_result_c;
      BUS_PC:  bus_c = DATA_WIDTH'(pc);
      default: bus_c = '0;
    endcase
  end

  // Register file, flags and PC; halt freezes everything here
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_ir  <= '0;
      reg_out <= '0;
      pc      <= '0;
      mar     <= '0;
      flags   <= '0;
    end else if (!i_halt) begin
      if (i_register_a_in)      reg_a   <= bus_c;
      if (i_register_b_in)      reg_b   <= bus_c;
      if (i_instruction_in)     reg_ir  <= bus_c;
      if (i_register_output_in) reg_out <= bus_c;
      if (i_memory_address_in)  mar     <= bus_c[ADDR_WIDTH-1:0];
      if (i_register_flags_in) begin
        flags.carry <= alu_carry_c;
        flags.zero  <= alu_zero_c;
      end
      if (i_program_counter_jump) begin
        pc <= bus_c[ADDR_WIDTH-1:0];
      end else if (i_program_counter_increment) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
    end
  end

  // RAM is not reset; the load port wins over a bus write and works during halt
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (i_prog_we) begin
        ram[i_prog_addr] <= i_prog_data;
      end else if (i_ram_in && !i_halt) begin
        ram[mar] <= bus_c;
      end
    end
  end

`ifdef SAP_BUS_CHECK_EN
  logic [4:0] bus_drivers_c;
  logic       bus_conflict;

  assign bus_drivers_c = {i_instruction_out, i_ram_out, i_register_a_out,
                          i_alu_out, i_program_counter_out};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bus_conflict <= 1'b0;
    end else if ($countones(bus_drivers_c) > 1) begin
      bus_conflict <= 1'b1;
      $display("ERROR: bus conflict, drivers {io,ro,ao,eo,co} = %b", bus_drivers_c);
    end
  end

  assign o_bus_conflict = bus_conflict;
`else
  assign o_bus_conflict = 1'b0;
`endif

  assign o_opcode        = reg_ir[DATA_WIDTH-1:ADDR_WIDTH];
  assign o_flag_overflow = flags.carry;
  assign o_flag_zero     = flags.zero;
  assign o_out           = reg_out;
  assign o_pc            = pc;
  assign o_bus           = bus_c;

endmodule
